// File: rtl/survivor_pkg.sv
// Shared types and helpers for the survivor-path memory.
package survivor_pkg;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StRead = 1'b1
  } tb_state_e;

  function automatic int unsigned word_w(input int unsigned state_num,
                                         input int unsigned state_reg_num);
    return state_num * state_reg_num;
  endfunction

endpackage

// File: rtl/param_def.sv
// Default generics for the survivor-path memory; the top falls back to the same values
// when this file is not part of the compile.
`ifndef MAX_STATE_NUM
`define MAX_STATE_NUM 256
`endif
`ifndef MAX_STATE_REG_NUM
`define MAX_STATE_REG_NUM 8
`endif
`ifndef TRACEBACK_DEPTH
`define TRACEBACK_DEPTH 64
`endif

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered read.
module sdp_ram #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/survivor_mem_pingpong.sv
// Ping-pong survivor-path memory: one bank fills in step order while the other
// streams out newest-first to the traceback unit.
`ifndef MAX_STATE_NUM
`define MAX_STATE_NUM 256
`endif
`ifndef MAX_STATE_REG_NUM
`define MAX_STATE_REG_NUM 8
`endif
`ifndef TRACEBACK_DEPTH
`define TRACEBACK_DEPTH 64
`endif

module survivor_mem_pingpong
  import survivor_pkg::*;
#(
  parameter int unsigned STATE_NUM     = `MAX_STATE_NUM,
  parameter int unsigned STATE_REG_NUM = `MAX_STATE_REG_NUM,
  parameter int unsigned TB_DEPTH      = `TRACEBACK_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en_m,
  input  logic                     i_valid,
  input  logic [STATE_REG_NUM-1:0] i_fwd_prv_st [STATE_NUM],
  output logic                     o_ready,
  output logic [STATE_REG_NUM-1:0] o_bck_prv_st [STATE_NUM],
  output logic                     o_valid,
  output logic                     o_first,
  output logic                     o_last,
  output logic                     o_sync
);

  localparam int unsigned WordW = word_w(STATE_NUM, STATE_REG_NUM);
  localparam int unsigned IdxW  = $clog2(TB_DEPTH);
  localparam int unsigned AddrW = IdxW + 1;
  localparam logic [IdxW-1:0] IdxMax = IdxW'(TB_DEPTH - 1);

  logic [IdxW-1:0]  wr_idx_q;
  logic [IdxW-1:0]  rd_idx_q;
  logic             wr_bank_q;
  logic             rd_bank_q;
  logic [1:0]       full_q;
  logic [1:0]       full_d;
  tb_state_e        state_q;
  logic             wr_en;
  logic             wr_wrap;
  logic             rd_issue;
  logic             rd_wrap;
  logic [WordW-1:0] wr_word;
  logic [WordW-1:0] rd_word;
  logic             rd_valid_q;
  logic             rd_first_q;
  logic             rd_last_q;

  assign o_ready  = en_m && !full_q[wr_bank_q];
  assign wr_en    = i_valid && o_ready;
  assign wr_wrap  = wr_en && (wr_idx_q == IdxMax);
  assign rd_issue = en_m && (state_q == StRead);
  assign rd_wrap  = rd_issue && (rd_idx_q == '0);

  always_comb begin
    wr_word = '0;
    for (int k = 0; k < STATE_NUM; k++) begin
      wr_word[k*STATE_REG_NUM +: STATE_REG_NUM] = i_fwd_prv_st[k];
    end
  end

  // Writer only sets full on its own bank, reader only clears its own, so both may
  // land in the same cycle without conflict.
  always_comb begin
    full_d = full_q;
    if (wr_wrap) begin
      full_d[wr_bank_q] = 1'b1;
    end
    if (rd_wrap) begin
      full_d[rd_bank_q] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_idx_q  <= '0;
      wr_bank_q <= 1'b0;
      full_q    <= '0;
      o_sync    <= 1'b0;
    end else if (en_m) begin
      full_q <= full_d;
      if (wr_en) begin
        wr_idx_q <= wr_idx_q + IdxW'(1);
      end
      if (wr_wrap) begin
        wr_bank_q <= ~wr_bank_q;
        o_sync    <= 1'b1;
      end
    end
  end

  // Chaining straight into the other bank uses the registered full bit only: a bank
  // completing this very edge is picked up from IDLE next cycle, which keeps the
  // write-to-read distance of any word at two cycles or more.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      rd_idx_q  <= '0;
      rd_bank_q <= 1'b0;
    end else if (en_m) begin
      case (state_q)
        StIdle: begin
          if (full_q[rd_bank_q]) begin
            state_q  <= StRead;
            rd_idx_q <= IdxMax;
          end
        end
        StRead: begin
          rd_idx_q <= rd_idx_q - IdxW'(1);
          if (rd_idx_q == '0) begin
            rd_bank_q <= ~rd_bank_q;
            if (!full_q[~rd_bank_q]) begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  sdp_ram #(
    .WIDTH (WordW),
    .DEPTH (2 * TB_DEPTH),
    .ADDR_W(AddrW)
  ) u_ram (
    .clk  (clk),
    .we   (wr_en),
    .waddr({wr_bank_q, wr_idx_q}),
    .wdata(wr_word),
    .re   (en_m),
    .raddr({rd_bank_q, rd_idx_q}),
    .rdata(rd_word)
  );

  // Flags ride alongside the RAM read stage so they line up with the data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid_q <= 1'b0;
      rd_first_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else if (en_m) begin
      rd_valid_q <= rd_issue;
      rd_first_q <= (rd_idx_q == IdxMax);
      rd_last_q  <= (rd_idx_q == '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_valid <= 1'b0;
      o_first <= 1'b0;
      o_last  <= 1'b0;
      for (int k = 0; k < STATE_NUM; k++) begin
        o_bck_prv_st[k] <= '0;
      end
    end else if (en_m) begin
      o_valid <= rd_valid_q;
      o_first <= rd_valid_q && rd_first_q;
      o_last  <= rd_valid_q && rd_last_q;
      for (int k = 0; k < STATE_NUM; k++) begin
        o_bck_prv_st[k] <= rd_word[k*STATE_REG_NUM +: STATE_REG_NUM];
      end
    end
  end

  a_full_exclusive: assert property (@(posedge clk) disable iff (!rst)
    !(wr_wrap && rd_wrap && (wr_bank_q == rd_bank_q)));

endmodule

// File: tb/tb_survivor_mem_pingpong.sv
// Scoreboard bench: a small 4x2-bit, depth-8 instance for the directed scenarios and a
// default-sized instance for the wide random run.
module tb_survivor_mem_pingpong;

  logic clk;
  logic rst;
  logic en_m;

  // Small instance.
  logic       i_valid_a;
  logic [1:0] fwd_a [4];
  logic       o_ready_a;
  logic [1:0] bck_a [4];
  logic       o_valid_a, o_first_a, o_last_a, o_sync_a;
  logic [7:0] in_word_a, out_word_a;

  // Default-sized instance.
  logic          i_valid_b;
  logic [7:0]    fwd_b [256];
  logic          o_ready_b;
  logic [7:0]    bck_b [256];
  logic          o_valid_b, o_first_b, o_last_b, o_sync_b;
  logic [2047:0] in_word_b, out_word_b;

  typedef struct {
    logic [7:0] data;
    logic       first;
    logic       last;
  } ent_a_t;

  typedef struct {
    logic [2047:0] data;
    logic          first;
    logic          last;
  } ent_b_t;

  ent_a_t     exp_a [$];
  logic [7:0] buf_a [$];
  ent_b_t        exp_b [$];
  logic [2047:0] buf_b [$];
  ent_a_t pop_a;
  ent_b_t pop_b;

  int checks = 0;
  int errors = 0;
  int nvalid_a = 0;
  int nvalid_b = 0;
  int en_cyc = 0;
  int first_valid = -1;
  int last_valid = -1;
  int blk_start = 0;
  int max_stall = 0;

  survivor_mem_pingpong #(
    .STATE_NUM    (4),
    .STATE_REG_NUM(2),
    .TB_DEPTH     (8)
  ) u_dut_a (
    .clk         (clk),
    .rst         (rst),
    .en_m        (en_m),
    .i_valid     (i_valid_a),
    .i_fwd_prv_st(fwd_a),
    .o_ready     (o_ready_a),
    .o_bck_prv_st(bck_a),
    .o_valid     (o_valid_a),
    .o_first     (o_first_a),
    .o_last      (o_last_a),
    .o_sync      (o_sync_a)
  );

  survivor_mem_pingpong u_dut_b (
    .clk         (clk),
    .rst         (rst),
    .en_m        (en_m),
    .i_valid     (i_valid_b),
    .i_fwd_prv_st(fwd_b),
    .o_ready     (o_ready_b),
    .o_bck_prv_st(bck_b),
    .o_valid     (o_valid_b),
    .o_first     (o_first_b),
    .o_last      (o_last_b),
    .o_sync      (o_sync_b)
  );

  always_comb begin
    in_word_a  = '0;
    out_word_a = '0;
    for (int k = 0; k < 4; k++) begin
      in_word_a[k*2 +: 2]  = fwd_a[k];
      out_word_a[k*2 +: 2] = bck_a[k];
    end
  end

  always_comb begin
    in_word_b  = '0;
    out_word_b = '0;
    for (int k = 0; k < 256; k++) begin
      in_word_b[k*8 +: 8]  = fwd_b[k];
      out_word_b[k*8 +: 8] = bck_b[k];
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard for the small instance: accepted writes collect per bank and are queued
  // newest-first once the bank is complete.
  always @(negedge clk) begin
    if (!rst) begin
      exp_a.delete();
      buf_a.delete();
    end else begin
      if (en_m) en_cyc++;
      if (en_m && o_valid_a) begin
        nvalid_a++;
        if (first_valid < 0) first_valid = en_cyc;
        last_valid = en_cyc;
        if (o_first_a) blk_start = en_cyc;
        if (o_last_a) check("blk_len", 64'(en_cyc - blk_start), 7);
        check("sb_nonempty", exp_a.size() != 0, 1);
        if (exp_a.size() != 0) begin
          pop_a = exp_a.pop_front();
          check("data", out_word_a, pop_a.data);
          check("first", o_first_a, pop_a.first);
          check("last", o_last_a, pop_a.last);
        end
      end
      if (i_valid_a && o_ready_a) begin
        buf_a.push_back(in_word_a);
        if (buf_a.size() == 8) begin
          for (int i = 7; i >= 0; i--) exp_a.push_back('{buf_a[i], (i == 7), (i == 0)});
          buf_a.delete();
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      exp_b.delete();
      buf_b.delete();
    end else begin
      if (en_m && o_valid_b) begin
        nvalid_b++;
        check("b_nonempty", exp_b.size() != 0, 1);
        if (exp_b.size() != 0) begin
          pop_b = exp_b.pop_front();
          check("b_data", out_word_b == pop_b.data, 1);
          check("b_first", o_first_b, pop_b.first);
          check("b_last", o_last_b, pop_b.last);
        end
      end
      if (i_valid_b && o_ready_b) begin
        buf_b.push_back(in_word_b);
        if (buf_b.size() == 64) begin
          for (int i = 63; i >= 0; i--) exp_b.push_back('{buf_b[i], (i == 63), (i == 0)});
          buf_b.delete();
        end
      end
    end
  end

  task automatic burst_a(input int n, input bit step_pat);
    int sent = 0;
    int guard = 0;
    int stall = 0;
    logic acc;
    while (sent < n && guard < 8 * n + 100) begin
      i_valid_a = 1'b1;
      for (int k = 0; k < 4; k++) fwd_a[k] = step_pat ? 2'(sent) : 2'($urandom_range(0, 3));
      @(negedge clk);
      acc = o_ready_a;
      if (!acc) begin
        stall++;
        if (stall > max_stall) max_stall = stall;
      end else begin
        stall = 0;
      end
      @(posedge clk);
      #1;
      if (acc) sent++;
      guard++;
    end
    i_valid_a = 1'b0;
    check("burst_a_sent", sent, n);
  endtask

  task automatic burst_b(input int n);
    int sent = 0;
    int guard = 0;
    logic acc;
    while (sent < n && guard < 4 * n + 200) begin
      i_valid_b = 1'b1;
      for (int k = 0; k < 256; k++) fwd_b[k] = 8'($urandom_range(0, 255));
      @(negedge clk);
      acc = o_ready_b;
      @(posedge clk);
      #1;
      if (acc) sent++;
      guard++;
    end
    i_valid_b = 1'b0;
    check("burst_b_sent", sent, n);
  endtask

  task automatic drain_a();
    int g = 0;
    while (exp_a.size() != 0 && g < 300) begin
      @(posedge clk);
      g++;
    end
    repeat (4) @(posedge clk);
    #1;
    check("drain_a", exp_a.size(), 0);
  endtask

  task automatic drain_b();
    int g = 0;
    while (exp_b.size() != 0 && g < 1000) begin
      @(posedge clk);
      g++;
    end
    repeat (4) @(posedge clk);
    #1;
    check("drain_b", exp_b.size(), 0);
  endtask

  // One bank of st[k] = step, then the output window relative to the last write edge.
  task automatic run_single();
    check("t1_sync_pre", o_sync_a, 0);
    burst_a(8, 1'b1);
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      check("t1_valid", o_valid_a, (j >= 3 && j <= 10));
      if (j == 1) check("t1_sync", o_sync_a, 1);
    end
    drain_a();
  endtask

  initial begin
    rst = 1'b0;
    en_m = 1'b0;
    i_valid_a = 1'b0;
    i_valid_b = 1'b0;
    for (int k = 0; k < 4; k++) fwd_a[k] = '0;
    for (int k = 0; k < 256; k++) fwd_b[k] = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    en_m = 1'b1;
    #1;
    check("rst_valid", o_valid_a, 0);
    check("rst_first", o_first_a, 0);
    check("rst_last", o_last_a, 0);
    check("rst_sync", o_sync_a, 0);
    check("rst_data", out_word_a, 0);
    check("rst_ready", o_ready_a, 1);
    check("rst_b_valid", o_valid_b, 0);
    @(posedge clk);
    #1;

    // Single bank.
    run_single();

    // Continuous stream of 64 words.
    max_stall = 0;
    nvalid_a = 0;
    burst_a(64, 1'b0);
    drain_a();
    check("t2_count", nvalid_a, 64);
    check("t2_stall_le2", max_stall <= 2, 1);

    // Both banks full: 16 back-to-back words from idle.
    nvalid_a = 0;
    first_valid = -1;
    burst_a(16, 1'b0);
    @(negedge clk);
    check("t3_ready_both_full", o_ready_a, 0);
    @(negedge clk);
    check("t3_ready_back", o_ready_a, 1);
    drain_a();
    check("t3_count", nvalid_a, 16);
    check("t3_span", 64'(last_valid - first_valid + 1), 16);

    // en_m freeze mid-write, then mid-read.
    nvalid_a = 0;
    burst_a(3, 1'b0);
    en_m = 1'b0;
    i_valid_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_frz_wr_ready", o_ready_a, 0);
      @(posedge clk);
      #1;
    end
    en_m = 1'b1;
    burst_a(5, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    en_m = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_frz_valid", o_valid_a, 1);
      check("t4_frz_ready", o_ready_a, 0);
      if (exp_a.size() != 0) check("t4_frz_data", out_word_a, exp_a[0].data);
      @(posedge clk);
      #1;
    end
    en_m = 1'b1;
    drain_a();
    check("t4_count", nvalid_a, 8);

    // Asynchronous reset mid-read while the next bank is partly written.
    burst_a(11, 1'b0);
    @(posedge clk);
    #1;
    i_valid_a = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check("t5_valid", o_valid_a, 0);
    check("t5_first", o_first_a, 0);
    check("t5_last", o_last_a, 0);
    check("t5_sync", o_sync_a, 0);
    check("t5_data", out_word_a, 0);
    check("t5_ready", o_ready_a, 1);
    i_valid_a = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    run_single();

    // Default-sized instance: 128 random words.
    nvalid_b = 0;
    burst_b(128);
    drain_b();
    check("t6_count", nvalid_b, 128);
    check("t6_sync", o_sync_b, 1);

    check("sb_a_left", exp_a.size(), 0);
    check("sb_b_left", exp_b.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
